// File: rtl/cronometro_display_if.sv
// Pin-side bundle of the stopwatch display back end: binary time in, multiplexed 7-segment drive out.
// The stopwatch core is the master; cronometro_display is the slave.
interface cronometro_display_if;
    logic [6:0] cent_seg;
    logic [5:0] seg;
    logic       hold;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;
    logic       upd;
    logic [1:0] state_dbg;

    // No backpressure: inputs are sampled whenever the converter is idle and hold=0,
    // and upd is a single-cycle strobe the master may ignore.
    modport master (
        output cent_seg, seg, hold,
        input  seg_n, an_n, dp_n, upd, state_dbg
    );

    modport slave (
        input  cent_seg, seg, hold,
        output seg_n, an_n, dp_n, upd, state_dbg
    );
endinterface

// File: rtl/cronometro_display.sv
// Stopwatch display back end: sequential double-dabble of SS.CC plus a prescaled 4-digit anode scan.
// Optional feature macro: CRONO_DISP_LZB_EN blanks the seconds tens digit when it is zero.
module cronometro_display #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cronometro_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    // Shift registers laid out as {bcd tens, bcd units, binary}.
    logic [14:0] cent_sr_q, cent_sr_d;
    logic [14:0] sec_sr_q, sec_sr_d;
    logic [3:0]  d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic        upd_q, upd_d;
    logic [15:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic [3:0]  an_n_q, an_n_d;
    logic        dp_n_q, dp_n_d;

    logic [6:0]  cent_cl;
    logic [5:0]  sec_cl;
    logic [3:0]  cur_digit;

    function automatic logic [14:0] dabble_step(input logic [14:0] sr);
        logic [14:0] t;
        t = sr;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign cent_cl = (bus.cent_seg > 7'd99) ? 7'd99 : bus.cent_seg;
    assign sec_cl  = (bus.seg > 6'd59) ? 6'd59 : bus.seg;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cent_sr_d = cent_sr_q;
        sec_sr_d  = sec_sr_q;
        d3_d      = d3_q;
        d2_d      = d2_q;
        d1_d      = d1_q;
        d0_d      = d0_q;
        upd_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.hold) begin
                    cent_sr_d = {8'd0, cent_cl};
                    sec_sr_d  = {9'd0, sec_cl};
                    step_d    = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                cent_sr_d = dabble_step(cent_sr_q);
                sec_sr_d  = dabble_step(sec_sr_q);
                if (step_q == 3'd6) begin
                    step_d  = 3'd0;
                    state_d = UPDATE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            UPDATE: begin
                d3_d    = sec_sr_q[14:11];
                d2_d    = sec_sr_q[10:7];
                d1_d    = cent_sr_q[14:11];
                d0_d    = cent_sr_q[10:7];
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q + 16'd1;
        idx_d = idx_q;
        if (pre_q >= PRE_LAST) begin
            pre_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end

        case (idx_q)
            2'd0:    cur_digit = d0_q;
            2'd1:    cur_digit = d1_q;
            2'd2:    cur_digit = d2_q;
            default: cur_digit = d3_q;
        endcase

        seg_n_d = decode(cur_digit);
`ifdef CRONO_DISP_LZB_EN
        // Only the seconds tens digit is blanked; its anode keeps scanning.
        if (idx_q == 2'd3 && d3_q == 4'd0) seg_n_d = SEG_BLANK;
`else
        seg_n_d = seg_n_d;
`endif
        an_n_d = ~(4'b0001 << idx_q);
        dp_n_d = (idx_q != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            cent_sr_q <= 15'd0;
            sec_sr_q  <= 15'd0;
            d3_q      <= 4'd0;
            d2_q      <= 4'd0;
            d1_q      <= 4'd0;
            d0_q      <= 4'd0;
            upd_q     <= 1'b0;
            pre_q     <= 16'd0;
            idx_q     <= 2'd0;
            seg_n_q   <= SEG_BLANK;
            an_n_q    <= 4'hF;
            dp_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cent_sr_q <= cent_sr_d;
            sec_sr_q  <= sec_sr_d;
            d3_q      <= d3_d;
            d2_q      <= d2_d;
            d1_q      <= d1_d;
            d0_q      <= d0_d;
            upd_q     <= upd_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg_n_q   <= seg_n_d;
            an_n_q    <= an_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign bus.seg_n     = seg_n_q;
    assign bus.an_n      = an_n_q;
    assign bus.dp_n      = dp_n_q;
    assign bus.upd       = upd_q;
    assign bus.state_dbg = state_q;

endmodule
